memory_rr_arbiter: RTL and testbench

//  Shares one single-port memory (valid/ready, wr_rd, addr, w_data, r_data) between two requesters, A and B.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/memory_rr_arbiter_if.sv | 49 ++++
 rtl/rr_arb2.sv | 23 ++
 rtl/memory_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_memory_rr_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states, grant ids and the
// timeout counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } arb_state_e;

   localparam logic GrantA = 1'b0;
   localparam logic GrantB = 1'b1;

   localparam int unsigned CntWidth = 8;

   // Round-robin pick when both requesters are asking: whoever was not served last.
   function automatic logic rr_pick(input logic last_grant);
      return ~last_grant;
   endfunction

endpackage

// File: rtl/memory_rr_arbiter_if.sv
// Bundle of requester A/B handshakes and the memory-side bus. The slave modport is the
// arbiter's view; the master modport is the requesters and memory around it.
interface memory_rr_arbiter_if #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ADDR_WIDTH = 4
);

   logic [ADDR_WIDTH-1:0] a_addr_i;
   logic [WIDTH-1:0]      a_w_data_i;
   logic                  a_wr_rd_i;
   logic                  a_valid_i;
   logic                  a_ready_o;
   logic [WIDTH-1:0]      a_r_data_o;
   logic                  a_err_o;

   logic [ADDR_WIDTH-1:0] b_addr_i;
   logic [WIDTH-1:0]      b_w_data_i;
   logic                  b_wr_rd_i;
   logic                  b_valid_i;
   logic                  b_ready_o;
   logic [WIDTH-1:0]      b_r_data_o;
   logic                  b_err_o;

   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [WIDTH-1:0]      mem_w_data_o;
   logic                  mem_wr_rd_o;
   logic                  mem_valid_o;
   logic                  mem_ready_i;
   logic [WIDTH-1:0]      mem_r_data_i;

   modport slave (
      input  a_addr_i, a_w_data_i, a_wr_rd_i, a_valid_i,
      output a_ready_o, a_r_data_o, a_err_o,
      input  b_addr_i, b_w_data_i, b_wr_rd_i, b_valid_i,
      output b_ready_o, b_r_data_o, b_err_o,
      output mem_addr_o, mem_w_data_o, mem_wr_rd_o, mem_valid_o,
      input  mem_ready_i, mem_r_data_i
   );

   modport master (
      output a_addr_i, a_w_data_i, a_wr_rd_i, a_valid_i,
      input  a_ready_o, a_r_data_o, a_err_o,
      output b_addr_i, b_w_data_i, b_wr_rd_i, b_valid_i,
      input  b_ready_o, b_r_data_o, b_err_o,
      input  mem_addr_o, mem_w_data_o, mem_wr_rd_o, mem_valid_o,
      output mem_ready_i, mem_r_data_i
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision; purely combinational.
// req_i[0] is requester A, req_i[1] is requester B.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       any_req_o
);

   always_comb begin
      any_req_o = |req_i;
      grant_o   = GrantA;
      unique case (req_i)
         2'b01:   grant_o = GrantA;
         2'b10:   grant_o = GrantB;
         2'b11:   grant_o = rr_pick(last_grant_i);
         default: grant_o = GrantA;
      endcase
   end

endmodule

// File: rtl/memory_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready single-port memory between requesters A and B,
// with a per-access timeout that completes the access with an error flag.
module memory_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                clk_i,
   input  logic                rst_i,
   memory_rr_arbiter_if.slave  bus
);

   if (TIMEOUT == 0 || TIMEOUT > 255 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_param
      $error("memory_rr_arbiter: TIMEOUT must be 1..255 and DEPTH must fit ADDR_WIDTH");
   end

   localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [CntWidth-1:0]   cnt_inc;

   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]      mem_w_data_q, mem_w_data_d;
   logic                  mem_wr_rd_q, mem_wr_rd_d;
   logic                  mem_valid_q, mem_valid_d;

   logic                  a_ready_q, a_ready_d;
   logic                  a_err_q, a_err_d;
   logic [WIDTH-1:0]      a_r_data_q, a_r_data_d;
   logic                  b_ready_q, b_ready_d;
   logic                  b_err_q, b_err_d;
   logic [WIDTH-1:0]      b_r_data_q, b_r_data_d;

   logic                  arb_grant;
   logic                  arb_any;

   rr_arb2 u_rr_arb2 (
      .req_i        ({bus.b_valid_i, bus.a_valid_i}),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .any_req_o    (arb_any)
   );

   assign cnt_inc = cnt_q + CntWidth'(1);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_w_data_d = mem_w_data_q;
      mem_wr_rd_d  = mem_wr_rd_q;
      mem_valid_d  = mem_valid_q;
      a_r_data_d   = a_r_data_q;
      b_r_data_d   = b_r_data_q;
      a_ready_d    = 1'b0;
      b_ready_d    = 1'b0;
      a_err_d      = 1'b0;
      b_err_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (arb_any) begin
               grant_d     = arb_grant;
               mem_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = StBusy;
               if (arb_grant == GrantB) begin
                  mem_addr_d   = bus.b_addr_i;
                  mem_w_data_d = bus.b_w_data_i;
                  mem_wr_rd_d  = bus.b_wr_rd_i;
               end else begin
                  mem_addr_d   = bus.a_addr_i;
                  mem_w_data_d = bus.a_w_data_i;
                  mem_wr_rd_d  = bus.a_wr_rd_i;
               end
            end
         end

         StBusy: begin
            cnt_d = cnt_inc;
            // A ready arriving on the timeout cycle still counts as success.
            if (bus.mem_ready_i) begin
               mem_valid_d = 1'b0;
               state_d     = StResp;
               if (grant_q == GrantB) begin
                  b_ready_d = 1'b1;
                  if (!mem_wr_rd_q) b_r_data_d = bus.mem_r_data_i;
               end else begin
                  a_ready_d = 1'b1;
                  if (!mem_wr_rd_q) a_r_data_d = bus.mem_r_data_i;
               end
            end else if (cnt_inc == CntLimit) begin
               mem_valid_d = 1'b0;
               state_d     = StResp;
               if (grant_q == GrantB) begin
                  b_ready_d = 1'b1;
                  b_err_d   = 1'b1;
               end else begin
                  a_ready_d = 1'b1;
                  a_err_d   = 1'b1;
               end
            end
         end

         StResp: begin
            last_grant_d = grant_q;
            cnt_d        = '0;
            state_d      = StIdle;
         end

         default: begin
            mem_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         grant_q      <= GrantA;
         last_grant_q <= GrantB;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_w_data_q <= '0;
         mem_wr_rd_q  <= 1'b0;
         mem_valid_q  <= 1'b0;
         a_ready_q    <= 1'b0;
         a_err_q      <= 1'b0;
         a_r_data_q   <= '0;
         b_ready_q    <= 1'b0;
         b_err_q      <= 1'b0;
         b_r_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_w_data_q <= mem_w_data_d;
         mem_wr_rd_q  <= mem_wr_rd_d;
         mem_valid_q  <= mem_valid_d;
         a_ready_q    <= a_ready_d;
         a_err_q      <= a_err_d;
         a_r_data_q   <= a_r_data_d;
         b_ready_q    <= b_ready_d;
         b_err_q      <= b_err_d;
         b_r_data_q   <= b_r_data_d;
      end
   end

   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_w_data_o = mem_w_data_q;
   assign bus.mem_wr_rd_o  = mem_wr_rd_q;
   assign bus.mem_valid_o  = mem_valid_q;
   assign bus.a_ready_o    = a_ready_q;
   assign bus.a_err_o      = a_err_q;
   assign bus.a_r_data_o   = a_r_data_q;
   assign bus.b_ready_o    = b_ready_q;
   assign bus.b_err_o      = b_err_q;
   assign bus.b_r_data_o   = b_r_data_q;

endmodule

// File: tb/tb_memory_rr_arbiter.sv
// Self-checking bench for memory_rr_arbiter: directed vector table, streaming fairness,
// reset abort and randomized traffic against a transaction-level reference model.
module tb_memory_rr_arbiter;

   localparam int TO = 4;

   typedef struct {
      bit         wr;
      logic [3:0] addr;
      logic [7:0] data;
   } req_t;

   typedef struct {
      bit         who;
      int         cyc;
      logic [7:0] rdata;
      bit         err;
   } evt_t;

   typedef struct {
      bit         rst;
      int         w;
      bit         a_en;
      bit         a_wr;
      logic [3:0] a_addr;
      logic [7:0] a_d;
      bit         b_en;
      bit         b_wr;
      logic [3:0] b_addr;
      logic [7:0] b_d;
      bit         first;
      logic [7:0] ea;
      logic [7:0] eb;
      bit         eerr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   memory_rr_arbiter_if #(.WIDTH(8), .ADDR_WIDTH(4)) ifc ();

   memory_rr_arbiter #(
      .WIDTH      (8),
      .DEPTH      (16),
      .ADDR_WIDTH (4),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc)
   );

   // Memory device: registered ready after mem_wait extra cycles; mem_wait < 0 never answers.
   int         mem_wait = 0;
   logic [7:0] sram [16] = '{default: 8'h00};
   logic       mem_rdy = 1'b0;
   logic [7:0] mem_rdata = 8'h00;
   int         wcnt = 0;

   always @(posedge clk) begin
      if (!ifc.mem_valid_o) begin
         mem_rdy <= 1'b0;
         wcnt    <= 0;
      end else if (mem_rdy) begin
         mem_rdy <= 1'b0;
      end else if (mem_wait >= 0 && wcnt == mem_wait) begin
         mem_rdy <= 1'b1;
         if (ifc.mem_wr_rd_o) sram[ifc.mem_addr_o] <= ifc.mem_w_data_o;
         else mem_rdata <= sram[ifc.mem_addr_o];
      end else begin
         wcnt <= wcnt + 1;
      end
   end

   assign ifc.mem_ready_i  = mem_rdy;
   assign ifc.mem_r_data_i = mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model state
   req_t       qa[$];
   req_t       qb[$];
   req_t       ord_q[$];
   evt_t       exp_q[$];
   evt_t       act_q[$];
   int         exp_busy;
   bit         last_g;
   logic [7:0] ref_mem [16];
   logic [7:0] exp_rd [2];
   int         pa, pb;

   task automatic model_reset();
      last_g    = 1'b1;
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
   endtask

   // Walks the queued requests in service order and derives each completion cycle.
   task automatic predict(input int w);
      int   ia = 0;
      int   ib = 0;
      int   t = 0;
      int   d;
      bit   ok;
      bit   who;
      req_t r;
      exp_q.delete();
      ord_q.delete();
      exp_busy = 0;
      ok = (w >= 0) && (w + 2 <= TO);
      d  = ok ? 3 + w : TO + 1;
      while (ia < qa.size() || ib < qb.size()) begin
         if (ia < qa.size() && ib < qb.size()) who = ~last_g;
         else who = (ia < qa.size()) ? 1'b0 : 1'b1;
         if (who) begin r = qb[ib]; ib++; end
         else begin r = qa[ia]; ia++; end
         t += (exp_q.size() == 0) ? d : d + 1;
         if (ok) begin
            if (r.wr) ref_mem[r.addr] = r.data;
            else exp_rd[who] = ref_mem[r.addr];
         end
         exp_q.push_back('{who: who, cyc: t, rdata: exp_rd[who], err: !ok});
         ord_q.push_back(r);
         last_g   = who;
         exp_busy += d - 1;
      end
   endtask

   task automatic present_a();
      if (pa < qa.size()) begin
         ifc.a_valid_i  = 1'b1;
         ifc.a_wr_rd_i  = qa[pa].wr;
         ifc.a_addr_i   = qa[pa].addr;
         ifc.a_w_data_i = qa[pa].data;
      end else begin
         ifc.a_valid_i = 1'b0;
      end
   endtask

   task automatic present_b();
      if (pb < qb.size()) begin
         ifc.b_valid_i  = 1'b1;
         ifc.b_wr_rd_i  = qb[pb].wr;
         ifc.b_addr_i   = qb[pb].addr;
         ifc.b_w_data_i = qb[pb].data;
      end else begin
         ifc.b_valid_i = 1'b0;
      end
   endtask

   // Runs both queues as streaming requesters (next request shown as soon as ready is seen).
   task automatic run_stream(input int w, input string tag);
      int   cyc = 0;
      int   busy = 0;
      int   field_bad = 0;
      int   stray = 0;
      int   both = 0;
      int   budget;
      int   n;
      req_t r;
      mem_wait = w;
      predict(w);
      act_q.delete();
      pa = 0;
      pb = 0;
      budget = (qa.size() + qb.size()) * (TO + 4) + 10;
      present_a();
      present_b();
      while (act_q.size() < exp_q.size() && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ifc.mem_valid_o) begin
            busy++;
            if (act_q.size() < ord_q.size()) begin
               r = ord_q[act_q.size()];
               if (ifc.mem_addr_o !== r.addr || ifc.mem_wr_rd_o !== r.wr ||
                   ifc.mem_w_data_o !== r.data) field_bad++;
            end
         end
         if ((ifc.a_err_o && !ifc.a_ready_o) || (ifc.b_err_o && !ifc.b_ready_o)) stray++;
         if (ifc.a_ready_o && ifc.b_ready_o) both++;
         if (ifc.a_ready_o) begin
            act_q.push_back('{who: 1'b0, cyc: cyc, rdata: ifc.a_r_data_o, err: ifc.a_err_o});
            pa++;
            present_a();
         end
         if (ifc.b_ready_o) begin
            act_q.push_back('{who: 1'b1, cyc: cyc, rdata: ifc.b_r_data_o, err: ifc.b_err_o});
            pb++;
            present_b();
         end
      end
      @(negedge clk);
      if (ifc.a_ready_o || ifc.b_ready_o || ifc.mem_valid_o) stray++;
      check($sformatf("%s completions", tag), act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s ev%0d requester", tag, i), act_q[i].who, exp_q[i].who);
         check($sformatf("%s ev%0d cycle", tag, i), act_q[i].cyc, exp_q[i].cyc);
         check($sformatf("%s ev%0d r_data", tag, i), act_q[i].rdata, exp_q[i].rdata);
         check($sformatf("%s ev%0d err", tag, i), act_q[i].err, exp_q[i].err);
      end
      if (exp_q.size() > 0) begin
         check($sformatf("%s mem fields bad", tag), field_bad, 0);
         check($sformatf("%s mem_valid cycles", tag), busy, exp_busy);
      end
      check($sformatf("%s stray/overlap", tag), stray + both, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      ifc.a_valid_i = 1'b0;
      ifc.b_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t tbl [11];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.a_valid_i  = 1'b0;
      ifc.a_wr_rd_i  = 1'b0;
      ifc.a_addr_i   = '0;
      ifc.a_w_data_i = '0;
      ifc.b_valid_i  = 1'b0;
      ifc.b_wr_rd_i  = 1'b0;
      ifc.b_addr_i   = '0;
      ifc.b_w_data_i = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      model_reset();

      //          rst  w  aen awr aad    ad     ben bwr bad    bd    first ea     eb     err
      tbl[0]  = '{1,  0, 1, 1, 4'h3, 8'hA5, 0, 0, 4'h0, 8'h00, 0, 8'h00, 8'h00, 0};
      tbl[1]  = '{0,  0, 1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'hA5, 8'h00, 0};
      tbl[2]  = '{1,  0, 1, 1, 4'h1, 8'h11, 1, 1, 4'h2, 8'h22, 0, 8'h00, 8'h00, 0};
      tbl[3]  = '{0,  0, 1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 0, 8'h11, 8'h22, 0};
      tbl[4]  = '{0,  0, 0, 0, 4'h0, 8'h00, 1, 1, 4'hF, 8'h5A, 1, 8'h11, 8'h22, 0};
      tbl[5]  = '{0,  2, 1, 0, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h5A, 8'h22, 0};
      tbl[6]  = '{0, -1, 0, 0, 4'h0, 8'h00, 1, 0, 4'h2, 8'h00, 1, 8'h5A, 8'h22, 1};
      tbl[7]  = '{0, -1, 1, 1, 4'h4, 8'h77, 0, 0, 4'h0, 8'h00, 0, 8'h5A, 8'h22, 1};
      tbl[8]  = '{0,  0, 1, 0, 4'h4, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00, 8'h22, 0};
      tbl[9]  = '{0,  2, 0, 0, 4'h0, 8'h00, 1, 1, 4'h4, 8'h33, 1, 8'h00, 8'h22, 0};
      tbl[10] = '{0,  0, 1, 0, 4'h4, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h33, 8'h22, 0};

      repeat (2) @(negedge clk);
      check("reset mem_valid", ifc.mem_valid_o, 0);
      check("reset ready", {ifc.a_ready_o, ifc.b_ready_o}, 0);
      check("reset err", {ifc.a_err_o, ifc.b_err_o}, 0);
      check("reset r_data", {ifc.a_r_data_o, ifc.b_r_data_o}, 0);
      check("reset mem fields", {ifc.mem_addr_o, ifc.mem_w_data_o, ifc.mem_wr_rd_o}, 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         string tag;
         bit    any_err;
         tag = $sformatf("vec%0d", i);
         if (tbl[i].rst) do_reset();
         qa.delete();
         qb.delete();
         if (tbl[i].a_en) qa.push_back('{wr: tbl[i].a_wr, addr: tbl[i].a_addr, data: tbl[i].a_d});
         if (tbl[i].b_en) qb.push_back('{wr: tbl[i].b_wr, addr: tbl[i].b_addr, data: tbl[i].b_d});
         run_stream(tbl[i].w, tag);
         if (act_q.size() > 0) check({tag, " first grant"}, act_q[0].who, tbl[i].first);
         else check({tag, " first grant present"}, 0, 1);
         any_err = 1'b0;
         foreach (act_q[k]) any_err |= act_q[k].err;
         check({tag, " a_r_data"}, ifc.a_r_data_o, tbl[i].ea);
         check({tag, " b_r_data"}, ifc.b_r_data_o, tbl[i].eb);
         check({tag, " err"}, any_err, tbl[i].eerr);
      end

      // Both requesters stream six writes each, then read them back.
      do_reset();
      qa.delete();
      qb.delete();
      for (int i = 0; i < 6; i++) begin
         qa.push_back('{wr: 1'b1, addr: 4'(i), data: 8'(8'h40 + i)});
         qb.push_back('{wr: 1'b1, addr: 4'(8 + i), data: 8'(8'h80 + i)});
      end
      run_stream(0, "fair_wr");
      check("fair_wr pulses", act_q.size(), 12);
      for (int i = 0; i < act_q.size(); i++) check($sformatf("fair_wr alt%0d", i), act_q[i].who, i % 2);
      for (int i = 0; i < 6; i++) begin
         qa[i].wr = 1'b0;
         qb[i].wr = 1'b0;
      end
      run_stream(1, "fair_rd");

      // Reset while an access is stuck in BUSY.
      mem_wait       = -1;
      ifc.a_valid_i  = 1'b1;
      ifc.a_wr_rd_i  = 1'b1;
      ifc.a_addr_i   = 4'h7;
      ifc.a_w_data_i = 8'h99;
      repeat (2) @(negedge clk);
      check("abort mem_valid before reset", ifc.mem_valid_o, 1);
      rst           = 1'b1;
      ifc.a_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("abort mem_valid after reset", ifc.mem_valid_o, 0);
      check("abort outputs after reset",
            {ifc.a_ready_o, ifc.b_ready_o, ifc.a_err_o, ifc.b_err_o, ifc.a_r_data_o,
             ifc.b_r_data_o}, 0);
      begin
         int spurious = 0;
         repeat (6) begin
            @(negedge clk);
            if (ifc.a_ready_o || ifc.b_ready_o || ifc.mem_valid_o) spurious++;
         end
         check("abort no ready", spurious, 0);
      end
      qa.delete();
      qb.delete();
      qa.push_back('{wr: 1'b0, addr: 4'h3, data: 8'h00});
      qa.push_back('{wr: 1'b0, addr: 4'h7, data: 8'h00});
      run_stream(0, "post_abort");

      // Randomized traffic with random memory wait states, including no answer at all.
      for (int it = 0; it < 30; it++) begin
         int w;
         int na;
         int nb;
         qa.delete();
         qb.delete();
         na = int'($urandom_range(0, 3));
         nb = int'($urandom_range(0, 3));
         for (int k = 0; k < na; k++)
            qa.push_back('{wr: 1'($urandom), addr: 4'($urandom), data: 8'($urandom)});
         for (int k = 0; k < nb; k++)
            qb.push_back('{wr: 1'($urandom), addr: 4'($urandom), data: 8'($urandom)});
         w = int'($urandom_range(0, 3));
         if (w == 3) w = -1;
         run_stream(w, $sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
